lc3_mem_resp: RTL and testbench

LC3_MEM_RESP -- requirements
Module: lc3_mem_resp

---
 rtl/lc3_mem_resp.sv | 119 +++++++++++
 tb/tb_lc3_mem_resp.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/lc3_mem_resp.sv
// lc3_mem_resp: LC-3 memory responder with direct/indirect (LDI/STI) access and fixed read latency.
// Optional MEM_OOR_ERR_EN: final addresses beyond the memory depth are rejected and flagged on err_out.
module lc3_mem_resp #(
    parameter int ADDR_W = 8,
    parameter int RD_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [15:0] addr_in,
    input  logic        wea_in,
    input  logic        ind_in,
    input  logic [15:0] wdata_in,
    output logic        req_ready,
    output logic [15:0] rdata_out,
    output logic        rdata_valid,
`ifdef MEM_OOR_ERR_EN
    output logic        err_out,
`endif
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, ACCESS, IND, RESP} state_t;

    localparam logic [2:0]  CNT_LAST = 3'(RD_LAT - 1);
    localparam logic [15:0] HI_MASK  = ~16'((32'd1 << ADDR_W) - 32'd1);

    logic [15:0] mem [2**ADDR_W];

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] rdata_q, rdata_d;
    logic        wea_q, wea_d;
    logic        ind_q, ind_d;
    logic        accept, counting, last, done, oor, we;
    logic [15:0] mem_rd;

    // The full 16-bit working address is kept so an indirect pointer's upper bits can be checked.
`ifdef MEM_OOR_ERR_EN
    logic err_q, err_d;
    assign oor = |(addr_q & HI_MASK);
`else
    logic unused_hi;
    assign unused_hi = ^addr_q;
    assign oor = 1'b0;
`endif

    assign mem_rd   = mem[addr_q[ADDR_W-1:0]];
    assign accept   = (state_q == IDLE) && req_valid;
    assign counting = (state_q == ACCESS) || (state_q == IND);
    assign last     = counting && (cnt_q == CNT_LAST);
    // done marks the last cycle of the final access stage (direct ACCESS or IND)
    assign done     = last && ((state_q == IND) || !ind_q);
    assign we       = done && wea_q && !oor;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            addr_q  <= 16'h0000;
            wdata_q <= 16'h0000;
            rdata_q <= 16'h0000;
            wea_q   <= 1'b0;
            ind_q   <= 1'b0;
`ifdef MEM_OOR_ERR_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            wea_q   <= wea_d;
            ind_q   <= ind_d;
`ifdef MEM_OOR_ERR_EN
            err_q   <= err_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (we)
            mem[addr_q[ADDR_W-1:0]] <= wdata_q;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = req_valid ? ACCESS : IDLE;
            ACCESS:  state_d = last ? (ind_q ? IND : RESP) : ACCESS;
            IND:     state_d = last ? RESP : IND;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d   = (counting && !last) ? cnt_q + 3'd1 : 3'd0;
        addr_d  = accept ? addr_in : (last && ind_q && state_q == ACCESS) ? mem_rd : addr_q;
        wdata_d = accept ? wdata_in : wdata_q;
        wea_d   = accept ? wea_in : wea_q;
        ind_d   = accept ? ind_in : ind_q;
        rdata_d = done ? (oor ? 16'h0000 : wea_q ? rdata_q : mem_rd) : rdata_q;
`ifdef MEM_OOR_ERR_EN
        err_d   = done ? oor : err_q;
`endif
    end

    always_comb begin
        req_ready   = (state_q == IDLE) && !rst;
        busy        = state_q != IDLE;
        rdata_valid = state_q == RESP;
        rdata_out   = rdata_q;
`ifdef MEM_OOR_ERR_EN
        err_out     = (state_q == RESP) && err_q;
`endif
    end
endmodule

// File: tb/tb_lc3_mem_resp.sv
// tb_lc3_mem_resp: randomized self-checking bench for lc3_mem_resp against a word-array reference model.
module tb_lc3_mem_resp;
    localparam int RD_LAT = 2;
`ifdef MEM_OOR_ERR_EN
    localparam bit OOR = 1'b1;
`else
    localparam bit OOR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic [15:0] addr_in = 16'h0;
    logic        wea_in = 1'b0;
    logic        ind_in = 1'b0;
    logic [15:0] wdata_in = 16'h0;
    logic        req_ready, rdata_valid, busy;
    logic [15:0] rdata_out;
`ifdef MEM_OOR_ERR_EN
    logic        err_out;
`endif

    logic [15:0] ref_mem [256];
    logic [15:0] last_rd = 16'h0;
    int checks = 0;
    int failures = 0;

    lc3_mem_resp #(.ADDR_W(8), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .addr_in(addr_in),
        .wea_in(wea_in), .ind_in(ind_in), .wdata_in(wdata_in),
        .req_ready(req_ready), .rdata_out(rdata_out), .rdata_valid(rdata_valid),
`ifdef MEM_OOR_ERR_EN
        .err_out(err_out),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic wait_ready();
        int k = 0;
        while (!req_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("ready", 32'(req_ready), 32'd1);
    endtask

    // Called at a negedge; leaves the bench at the negedge after the response.
    task automatic do_txn(input logic w, input logic i, input logic [15:0] a, input logic [15:0] wd);
        logic [15:0] fa, exp_d;
        logic exp_e;
        int lat, k;
        fa    = i ? ref_mem[a[7:0]] : a;
        exp_e = OOR && (fa[15:8] != 8'h0);
        exp_d = exp_e ? 16'h0 : w ? last_rd : ref_mem[fa[7:0]];
        if (!exp_e && w) ref_mem[fa[7:0]] = wd;
        last_rd = exp_d;
        lat = i ? 2 * RD_LAT + 1 : RD_LAT + 1;
        wait_ready();
        req_valid = 1'b1; wea_in = w; ind_in = i; addr_in = a; wdata_in = wd;
        k = 0;
        do begin
            @(negedge clk);
            k++;
            if (k == 1) req_valid = 1'b0;
        end while (!rdata_valid && k < 40);
        check("latency", 32'(k), 32'(lat));
        check("rdata", 32'(rdata_out), 32'(exp_d));
`ifdef MEM_OOR_ERR_EN
        check("err", 32'(err_out), 32'(exp_e));
`endif
        @(negedge clk);
        check("one_pulse", 32'(rdata_valid), 32'd0);
    endtask

    // Start an indirect access and reset it during IND; memory must be untouched.
    task automatic abort_ind(input logic w, input logic [15:0] a, input logic [15:0] wd);
        int seen = 0;
        wait_ready();
        req_valid = 1'b1; wea_in = w; ind_in = 1'b1; addr_in = a; wdata_in = wd;
        for (int k = 1; k <= RD_LAT + 1; k++) begin
            @(negedge clk);
            if (k == 1) req_valid = 1'b0;
        end
        check("in_ind_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_ready_in_rst", 32'(req_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        last_rd = 16'h0;
        for (int k = 0; k < 2 * RD_LAT + 3; k++) begin
            if (rdata_valid) seen++;
            @(negedge clk);
        end
        check("abort_no_resp", 32'(seen), 32'd0);
        check("abort_rdata", 32'(rdata_out), 32'h0);
        check("abort_ready", 32'(req_ready), 32'd1);
    endtask

    initial begin
        int resp, p;
        logic [15:0] a;
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            if (k == 2) check("ready_in_rst", 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        rst = 1'b0;
        @(negedge clk);
        check("rst_rdata", 32'(rdata_out), 32'h0);
        check("rst_valid", 32'(rdata_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd1);
`ifdef MEM_OOR_ERR_EN
        check("rst_err", 32'(err_out), 32'd0);
`endif

        do_txn(1'b1, 1'b0, 16'h0010, 16'h1234);
        do_txn(1'b0, 1'b0, 16'h0010, 16'h0);
        check("rd_0010", 32'(last_rd), 32'h1234);
        do_txn(1'b1, 1'b0, 16'h0020, 16'h0030);
        do_txn(1'b1, 1'b0, 16'h0030, 16'hBEEF);
        do_txn(1'b0, 1'b1, 16'h0020, 16'h0);
        check("ldi_0020", 32'(last_rd), 32'hBEEF);
        abort_ind(1'b1, 16'h0020, 16'h5A5A);
        do_txn(1'b0, 1'b0, 16'h0030, 16'h0);
        check("abort_nowrite", 32'(last_rd), 32'hBEEF);
        do_txn(1'b1, 1'b1, 16'h0020, 16'h5A5A);
        do_txn(1'b0, 1'b0, 16'h0030, 16'h0);
        check("sti_target", 32'(last_rd), 32'h5A5A);
        do_txn(1'b0, 1'b0, 16'h0020, 16'h0);
        check("sti_ptr", 32'(last_rd), 32'h0030);
        do_txn(1'b0, 1'b0, 16'h0110, 16'h0);
        check("oor_0110", 32'(last_rd), OOR ? 32'h0 : 32'h1234);

        for (int k = 0; k < 256; k++)
            do_txn(1'b1, 1'b0, 16'(k), 16'($urandom));

        // Held req_valid: one response per acceptance, one acceptance per IDLE cycle.
        p = RD_LAT + 2;
        resp = 0;
        wait_ready();
        req_valid = 1'b1; wea_in = 1'b0; ind_in = 1'b0; addr_in = 16'h0042;
        for (int k = 1; k <= 7 * p; k++) begin
            @(negedge clk);
            if (k == 5 * p) req_valid = 1'b0;
            if (rdata_valid) begin
                resp++;
                check("hold_data", 32'(rdata_out), 32'(ref_mem[8'h42]));
            end
        end
        check("hold_count", 32'(resp), 32'd5);
        last_rd = ref_mem[8'h42];

        for (int n = 0; n < 300; n++) begin
            a = ($urandom_range(0, 3) == 0) ? 16'($urandom) : {8'h0, 8'($urandom)};
            if (n % 2 == 1) a[15:8] = 8'h0;
            do_txn(1'($urandom), ($urandom_range(0, 2) == 0), a, 16'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
